reg_writeback: RTL and testbench

//  Writeback stage that owns the reg_file write port (wren/rd_addr/data/is_load).

---
 rtl/rf_pkg.sv | 20 ++
 rtl/wb_arbiter.sv | 56 +++++
 rtl/reg_writeback.sv | 127 ++++++++++++
 tb/tb_reg_writeback.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback slice.
//   XLEN       data width
//   AW         register address width
//   NREGS      number of architectural registers (2**AW)
//   STARVE_MAX consecutive lost arbitrations an ALU result tolerates
//   wb_src_e   which producer owns the write port in a given cycle
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int NREGS      = 1 << AW;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter.sv
// One-write-per-cycle arbiter between the ALU and the load unit.
// Loads win ties so memory latency is not stretched further, but an ALU
// result that has lost STARVE_MAX consecutive cycles is granted next.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   alu_valid, ld_valid   producer has a result waiting
//   grant                 selected source this cycle (combinational)
//   alu_ready, ld_ready   handshake back to the producers (one-hot or zero)
module wb_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_MAX_P = STARVE_MAX
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    alu_valid,
  input  logic    ld_valid,
  output wb_src_e grant,
  output logic    alu_ready,
  output logic    ld_ready
);

  localparam int CW = (STARVE_MAX_P > 0) ? $clog2(STARVE_MAX_P + 1) : 1;

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX_P));

  always_comb begin
    // NOTE: default assignment first so every path drives grant; no latch.
    grant = WB_NONE;
    if (alu_valid && (!ld_valid || starved)) begin
      grant = WB_ALU;
    end else if (ld_valid) begin
      grant = WB_LOAD;
    end
  end

  assign alu_ready = (grant == WB_ALU);
  assign ld_ready  = (grant == WB_LOAD);

  // The counter cannot pass STARVE_MAX_P: once it gets there a valid ALU
  // result is always granted, which clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid || grant == WB_ALU) begin
      starve_cnt <= '0;
    end else begin
      // NOTE: non-blocking for all clocked state so every flop samples pre-edge values.
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: owns the register-file write port, arbitrates ALU and
// load results, and keeps the pending-write scoreboard used by decode.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   iss_valid/iss_rd/iss_ready       decode issue of a register-writing op
//   alu_valid/alu_rd/alu_data/ready  ALU result handshake
//   ld_valid/ld_rd/ld_data/ready     load result handshake
//   rf_wren (active-low), rf_rd_addr, rf_data, rf_is_load  register-file write
//   rs_addr1/2, hazard1/2            decode source lookup against the scoreboard
//   busy                             scoreboard, bit i = write to xi outstanding
//   wb_err                           sticky: result for a register not marked busy
module reg_writeback
  import rf_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int AW_P         = AW,
  parameter int STARVE_MAX_P = STARVE_MAX,
  parameter int NREGS_P      = 1 << AW_P
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  input  logic [AW_P-1:0]    iss_rd,
  output logic               iss_ready,
  input  logic               alu_valid,
  input  logic [AW_P-1:0]    alu_rd,
  input  logic [XLEN_P-1:0]  alu_data,
  output logic               alu_ready,
  input  logic               ld_valid,
  input  logic [AW_P-1:0]    ld_rd,
  input  logic [XLEN_P-1:0]  ld_data,
  output logic               ld_ready,
  output logic               rf_wren,
  output logic [AW_P-1:0]    rf_rd_addr,
  output logic [XLEN_P-1:0]  rf_data,
  output logic               rf_is_load,
  input  logic [AW_P-1:0]    rs_addr1,
  input  logic [AW_P-1:0]    rs_addr2,
  output logic               hazard1,
  output logic               hazard2,
  output logic [NREGS_P-1:0] busy,
  output logic               wb_err
);

  wb_src_e              grant;
  logic [AW_P-1:0]      sel_rd;
  logic [XLEN_P-1:0]    sel_data;
  logic                 issue_fire;
  logic [NREGS_P-1:0]   busy_next;

  wb_arbiter #(
    .STARVE_MAX_P(STARVE_MAX_P)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .ld_valid (ld_valid),
    .grant    (grant),
    .alu_ready(alu_ready),
    .ld_ready (ld_ready)
  );

  // x0 is hardwired, so issuing to it never waits on the scoreboard.
  assign iss_ready  = ~busy[iss_rd] | (iss_rd == '0);
  assign issue_fire = iss_valid & iss_ready & (iss_rd != '0);

  assign hazard1 = busy[rs_addr1] & (rs_addr1 != '0);
  assign hazard2 = busy[rs_addr2] & (rs_addr2 != '0);

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (grant == WB_LOAD) begin
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end
  end

  // The clear follows the registered write so the bit drops on the same
  // edge the register file commits. The set is applied last so it wins a
  // same-edge collision on one bit.
  always_comb begin
    busy_next = busy;
    if (!rf_wren) begin
      busy_next[rf_rd_addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the whole scoreboard is reset; decode must never see stale hazards after reset.
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_err <= 1'b0;
    end else if (grant != WB_NONE && sel_rd != '0 && !busy[sel_rd]) begin
      wb_err <= 1'b1;
    end
  end

  // A grant to x0 is consumed but leaves the write enable deasserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wren    <= 1'b1;
      rf_rd_addr <= '0;
      rf_data    <= '0;
      rf_is_load <= 1'b0;
    end else if (grant != WB_NONE) begin
      rf_wren    <= (sel_rd == '0);
      rf_rd_addr <= sel_rd;
      rf_data    <= sel_data;
      rf_is_load <= (grant == WB_LOAD);
    end else begin
      rf_wren    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
module tb_reg_writeback;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             iss_ready;
  logic             alu_valid;
  logic [AW-1:0]    alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ready;
  logic             ld_valid;
  logic [AW-1:0]    ld_rd;
  logic [XLEN-1:0]  ld_data;
  logic             ld_ready;
  logic             rf_wren;
  logic [AW-1:0]    rf_rd_addr;
  logic [XLEN-1:0]  rf_data;
  logic             rf_is_load;
  logic [AW-1:0]    rs_addr1;
  logic [AW-1:0]    rs_addr2;
  logic             hazard1;
  logic             hazard2;
  logic [NREGS-1:0] busy;
  logic             wb_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .rf_wren   (rf_wren),
    .rf_rd_addr(rf_rd_addr),
    .rf_data   (rf_data),
    .rf_is_load(rf_is_load),
    .rs_addr1  (rs_addr1),
    .rs_addr2  (rs_addr2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .busy      (busy),
    .wb_err    (wb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit [5:0] alu_turn;

  initial begin
    rst       = 1'b0;
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 32'h1111;
    ld_valid  = 1'b1;
    ld_rd     = 5'd2;
    ld_data   = 32'h2222;
    rs_addr1  = '0;
    rs_addr2  = '0;

    // 1: reset with valids high
    tick();
    tick();
    check("rst_wren", rf_wren, 1);
    check("rst_busy", busy, 0);
    check("rst_err", wb_err, 0);
    check("rst_addr", rf_rd_addr, 0);
    check("rst_data", rf_data, 0);
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("idle_wren", rf_wren, 1);
    check("idle_busy", busy, 0);

    // 2: issue x5, ALU writes it back
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    #1;
    check("iss5_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0;
    rs_addr1  = 5'd5;
    #1;
    check("busy5", busy, 32'h20);
    check("haz5_pre", hazard1, 1);
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    #1;
    check("alu5_ready", alu_ready, 1);
    check("alu5_ldready", ld_ready, 0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("wb5_wren", rf_wren, 0);
    check("wb5_addr", rf_rd_addr, 5);
    check("wb5_data", rf_data, 32'hDEADBEEF);
    check("wb5_isload", rf_is_load, 0);
    check("haz5_n1", hazard1, 1);
    tick();
    check("haz5_n2", hazard1, 0);
    check("wb5_done_wren", rf_wren, 1);
    check("busy5_clr", busy, 0);
    check("wb5_err", wb_err, 0);

    // 3: arbitration with both producers held for six cycles
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    tick();
    iss_rd    = 5'd4;
    tick();
    iss_valid = 1'b0;
    rs_addr1  = 5'd3;
    rs_addr2  = 5'd4;
    #1;
    check("busy34", busy, 32'h18);
    check("haz3", hazard1, 1);
    check("haz4", hazard2, 1);
    ld_valid  = 1'b1;
    ld_rd     = 5'd3;
    ld_data   = 32'h33;
    alu_valid = 1'b1;
    alu_rd    = 5'd4;
    alu_data  = 32'h44;
    alu_turn  = 6'b010000;  // bit i: cycle i goes to the ALU
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("arb%0d_alu", i), alu_ready, alu_turn[i]);
      check($sformatf("arb%0d_ld", i), ld_ready, !alu_turn[i]);
      check($sformatf("arb%0d_onehot", i), alu_ready & ld_ready, 0);
      tick();
      check($sformatf("arb%0d_wr_isload", i), rf_is_load, !alu_turn[i]);
      check($sformatf("arb%0d_wr_data", i), rf_data, alu_turn[i] ? 32'h44 : 32'h33);
    end
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
    // Repeated loads to x3 after its first commit hit a non-busy register.
    check("arb_err", wb_err, 1);
    check("arb_last_wren", rf_wren, 0);

    // Reset in the middle of a write
    rst = 1'b0;
    #1;
    check("midrst_wren", rf_wren, 1);
    check("midrst_busy", busy, 0);
    check("midrst_err", wb_err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 4: WAW block on x7
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    tick();
    #1;
    check("iss7_blocked", iss_ready, 0);
    tick();
    check("busy7_only", busy, 32'h80);
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    #1;
    check("iss0_ready", iss_ready, 1);
    alu_valid = 1'b1;
    alu_rd    = 5'd7;
    alu_data  = 32'h77;
    tick();
    alu_valid = 1'b0;
    tick();
    check("busy7_clr", busy, 0);
    iss_rd = 5'd7;
    #1;
    check("iss7_ready", iss_ready, 1);

    // 5: ALU result to x0
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'h1;
    #1;
    check("x0_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("x0_wren", rf_wren, 1);
    check("x0_busy", busy, 0);
    check("x0_err", wb_err, 0);

    // 6: result for a register that was never issued
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h99;
    tick();
    alu_valid = 1'b0;
    check("x9_wren", rf_wren, 0);
    check("x9_addr", rf_rd_addr, 9);
    check("x9_err", wb_err, 1);
    tick();
    tick();
    check("x9_err_sticky", wb_err, 1);
    check("x9_idle_wren", rf_wren, 1);
    check("x9_hold_data", rf_data, 32'h99);
    rst = 1'b0;
    #1;
    check("x9_err_rst", wb_err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
